// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

  // Port identifiers; also used as the round-robin "last served" pointer.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Byte addresses at or above this limit fall outside the 256-word memory.
  localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_0400;

  // Longest port B lock run allowed while port A is waiting.
  localparam int MAX_HOLD_DEF = 8;

  // Width of the word index taken from a byte address.
  localparam int WORD_IDX_W = 8;

  // Word index of a byte address (drops the byte offset).
  function automatic logic [WORD_IDX_W-1:0] word_idx(input logic [31:0] addr);
    return addr[WORD_IDX_W+1:2];
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata (and b_lock)
// and holds all of them stable until it sees x_gnt high at a rising edge;
// the access completes on that edge. x_gnt is a combinational response in
// the same cycle. A granted read returns x_rvalid/x_rdata one cycle later.
// Memory side: mem_read/mem_write are single-cycle strobes; mem_rdata is
// registered inside the memory and valid the cycle after mem_read.
interface dmem_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_gnt;
  logic        a_rvalid;
  logic [31:0] a_rdata;

  logic        b_req;
  logic        b_we;
  logic        b_lock;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_gnt;
  logic        b_rvalid;
  logic [31:0] b_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  // Requesters and memory view.
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a bounded burst lock for port B.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req_i,
  input  logic          b_req_i,
  input  logic          b_lock_i,
  output logic          a_gnt_o,
  output logic          b_gnt_o,
  output logic [HW-1:0] hold_cnt_o,
  output logic          locked_o
);

  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  port_e         last_q, last_d;
  logic          locked_q, locked_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          lock_win;

  // Grant selection: lock override, then round-robin tie break, then single requester.
  always_comb begin
    a_gnt_o  = 1'b0;
    b_gnt_o  = 1'b0;
    lock_win = locked_q & b_req_i & (hold_q < HOLD_MAX);
    if (reset) begin
      a_gnt_o = 1'b0;
      b_gnt_o = 1'b0;
    end else if (lock_win) begin
      b_gnt_o = 1'b1;
    end else if (a_req_i && b_req_i) begin
      if (last_q == PORT_B) a_gnt_o = 1'b1;
      else                  b_gnt_o = 1'b1;
    end else if (a_req_i) begin
      a_gnt_o = 1'b1;
    end else if (b_req_i) begin
      b_gnt_o = 1'b1;
    end
  end

  // Next-state for the last-served pointer, starvation counter and lock flag.
  always_comb begin
    last_d = last_q;
    if (a_gnt_o)      last_d = PORT_A;
    else if (b_gnt_o) last_d = PORT_B;

    hold_d = hold_q;
    if (a_gnt_o || !a_req_i) begin
      hold_d = '0;
    end else if (b_gnt_o && (hold_q < HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end

    // Lock survives only while B keeps winning with b_lock and A is not starved.
    locked_d = b_gnt_o & b_lock_i & (hold_d < HOLD_MAX);
  end

  // State registers; last starts at B so the first tie goes to A.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= PORT_B;
      locked_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      last_q   <= last_d;
      locked_q <= locked_d;
      hold_q   <= hold_d;
    end
  end

  assign hold_cnt_o = hold_q;
  assign locked_o   = locked_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage (A) and a
// secondary master (B): arbitration, memory muxing, range check and
// read-data return routing.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF,
  parameter int          MAX_HOLD   = MAX_HOLD_DEF,
  localparam int         HOLD_W     = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     bus,
  output logic              err,
  output logic [HOLD_W-1:0] dbg_hold_cnt_o,
  output logic              dbg_locked_o
);

  logic        a_gnt, b_gnt, any_gnt;
  logic        sel_we;
  logic        in_range;
  logic        rd_a_q, rd_a_d;
  logic        rd_b_q, rd_b_d;
  logic        rd_ok_q, rd_ok_d;
  logic        a_rvalid, b_rvalid;

  rr_arbiter2 #(
    .MAX_HOLD (MAX_HOLD),
    .HW       (HOLD_W)
  ) u_rr (
    .clk        (clk),
    .reset      (reset),
    .a_req_i    (bus.a_req),
    .b_req_i    (bus.b_req),
    .b_lock_i   (bus.b_lock),
    .a_gnt_o    (a_gnt),
    .b_gnt_o    (b_gnt),
    .hold_cnt_o (dbg_hold_cnt_o),
    .locked_o   (dbg_locked_o)
  );

  assign any_gnt   = a_gnt | b_gnt;
  assign bus.a_gnt = a_gnt;
  assign bus.b_gnt = b_gnt;

  // Memory drive: winner's address/data, port A when nobody wins.
  always_comb begin
    bus.mem_addr  = bus.a_addr;
    bus.mem_wdata = bus.a_wdata;
    sel_we        = bus.a_we;
    if (b_gnt) begin
      bus.mem_addr  = bus.b_addr;
      bus.mem_wdata = bus.b_wdata;
      sel_we        = bus.b_we;
    end
    in_range      = (bus.mem_addr < ADDR_LIMIT);
    bus.mem_read  = any_gnt & ~sel_we & in_range;
    bus.mem_write = any_gnt &  sel_we & in_range;
    err           = any_gnt & ~in_range;
  end

  // Remember who issued a read this cycle and whether it touched memory.
  always_comb begin
    rd_a_d  = a_gnt & ~bus.a_we;
    rd_b_d  = b_gnt & ~bus.b_we;
    rd_ok_d = in_range;
  end

  // Read-return tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_a_q  <= 1'b0;
      rd_b_q  <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  // Route returning data to its owner; out-of-range reads return zero and
  // a reset in the return cycle suppresses the pulse.
  always_comb begin
    a_rvalid     = rd_a_q & ~reset;
    b_rvalid     = rd_b_q & ~reset;
    bus.a_rvalid = a_rvalid;
    bus.b_rvalid = b_rvalid;
    bus.a_rdata  = (a_rvalid && rd_ok_q) ? bus.mem_rdata : 32'h0;
    bus.b_rdata  = (b_rvalid && rd_ok_q) ? bus.mem_rdata : 32'h0;
  end

endmodule
